// File: rtl/key_feed_pkg.sv
// Shared types and default sizing for the key phase feeder.
package key_feed_pkg;

    localparam int unsigned KEY_W_DEF   = 7;
    localparam int unsigned N_PHASE_DEF = 4;
    localparam int unsigned SPLIT_DEF   = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoading,
        StReady,
        StArmed
    } feed_state_e;

endpackage

// File: rtl/key_phase_feeder_if.sv
// Control/status bundle between a key source and the key phase feeder.
interface key_phase_feeder_if #(
    parameter int unsigned KEY_W   = key_feed_pkg::KEY_W_DEF,
    parameter int unsigned N_PHASE = key_feed_pkg::N_PHASE_DEF
);

    localparam int unsigned PH_W = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;

    logic             load_start;
    logic             key_sdi;
    logic             key_sdv;
    logic             arm;
    logic [KEY_W-1:0] key_out;
    logic [PH_W-1:0]  phase;
    logic             load_done;
    logic             armed;
    logic             load_err;

    modport master (
        output load_start, key_sdi, key_sdv, arm,
        input  key_out, phase, load_done, armed, load_err
    );

    modport slave (
        input  load_start, key_sdi, key_sdv, arm,
        output key_out, phase, load_done, armed, load_err
    );

endinterface

// File: rtl/key_shift_reg.sv
// Serial key capture: LSB-first shift into a staging register, committed as a
// key_a/key_b pair only when the final bit of a load is accepted.
module key_shift_reg
    import key_feed_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_shift,
    input  logic             i_sdi,
    output logic             o_done,
    output logic [KEY_W-1:0] o_key_a,
    output logic [KEY_W-1:0] o_key_b
);

    localparam int unsigned TOT_W = 2 * KEY_W;
    localparam int unsigned CNT_W = $clog2(TOT_W);

    logic [CNT_W-1:0] r_cnt;
    logic [TOT_W-1:0] r_stage;
    logic [TOT_W-1:0] w_stage_next;
    logic [KEY_W-1:0] r_key_a;
    logic [KEY_W-1:0] r_key_b;
    logic             w_last;

    // New bits enter at the top so the first bit ends up at index 0.
    assign w_stage_next = {i_sdi, r_stage[TOT_W-1:1]};
    assign w_last       = (r_cnt == CNT_W'(TOT_W - 1));
    assign o_done       = i_shift && w_last;
    assign o_key_a      = r_key_a;
    assign o_key_b      = r_key_b;

    // Staging register and bit counter; counter saturates at the last index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_stage <= '0;
        end else if (i_start) begin
            r_cnt   <= '0;
            r_stage <= '0;
        end else if (i_shift) begin
            r_stage <= w_stage_next;
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Committed keys change only when a complete load finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_a <= '0;
            r_key_b <= '0;
        end else if (o_done) begin
            r_key_a <= w_stage_next[KEY_W-1:0];
            r_key_b <= w_stage_next[TOT_W-1:KEY_W];
        end
    end

endmodule

// File: rtl/key_phase_feeder.sv
// Loads a key pair serially and, once armed, drives key A or key B to the
// downstream locked FSM depending on a free-running phase counter.
module key_phase_feeder
    import key_feed_pkg::*;
#(
    parameter int unsigned KEY_W   = KEY_W_DEF,
    parameter int unsigned N_PHASE = N_PHASE_DEF,
    parameter int unsigned SPLIT   = SPLIT_DEF
) (
    input  logic clk,
    input  logic rst,
    key_phase_feeder_if.slave bus
);

    localparam int unsigned PH_W = (N_PHASE > 1) ? $clog2(N_PHASE) : 1;

    feed_state_e      r_state;
    feed_state_e      w_state_next;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_next;
    logic [KEY_W-1:0] r_key_out;
    logic [KEY_W-1:0] w_key_out_next;
    logic [KEY_W-1:0] w_key_a;
    logic [KEY_W-1:0] w_key_b;
    logic             r_load_done;
    logic             r_load_err;
    logic             w_load_err_next;
    logic             w_shift;
    logic             w_done;

    // load_start dominates key_sdv, so a bit presented with it is dropped.
    assign w_shift = (r_state == StLoading) && bus.key_sdv && !bus.load_start;

    key_shift_reg #(
        .KEY_W(KEY_W)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .i_start(bus.load_start),
        .i_shift(w_shift),
        .i_sdi  (bus.key_sdi),
        .o_done (w_done),
        .o_key_a(w_key_a),
        .o_key_b(w_key_b)
    );

    // Next phase value; wraps at the period length.
    always_comb begin
        w_phase_next = r_phase + PH_W'(1);
        if (r_phase == PH_W'(N_PHASE - 1)) begin
            w_phase_next = '0;
        end
    end

    // Phase free-runs in every state so it tracks the downstream counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; arming waits for the period boundary.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.load_start) begin
                    w_state_next = StLoading;
                end
            end
            StLoading: begin
                if (w_done) begin
                    w_state_next = StReady;
                end
            end
            StReady: begin
                if (bus.load_start) begin
                    w_state_next = StLoading;
                end else if (bus.arm && (w_phase_next == '0)) begin
                    w_state_next = StArmed;
                end
            end
            StArmed: begin
                if (bus.load_start) begin
                    w_state_next = StLoading;
                end else if (!bus.arm) begin
                    w_state_next = StReady;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM output logic; key selected from the phase it will be shown with.
    always_comb begin
        w_key_out_next  = '0;
        w_load_err_next = r_load_err;
        if (w_state_next == StArmed) begin
            w_key_out_next = (32'(w_phase_next) < SPLIT) ? w_key_a : w_key_b;
        end
        if ((r_state == StLoading) && bus.load_start) begin
            w_load_err_next = 1'b1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_out   <= '0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_key_out   <= w_key_out_next;
            r_load_done <= w_done;
            r_load_err  <= w_load_err_next;
        end
    end

    assign bus.key_out   = r_key_out;
    assign bus.phase     = r_phase;
    assign bus.load_done = r_load_done;
    assign bus.armed     = (r_state == StArmed);
    assign bus.load_err  = r_load_err;

endmodule

// File: tb/tb_key_phase_feeder.sv
// Directed bench for key_phase_feeder with a key-pair scoreboard.
module tb_key_phase_feeder;
    import key_feed_pkg::*;

    localparam int KW = 7;
    localparam int NP = 4;
    localparam int SP = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    key_phase_feeder_if #(.KEY_W(KW), .N_PHASE(NP)) bus ();

    key_phase_feeder #(
        .KEY_W  (KW),
        .N_PHASE(NP),
        .SPLIT  (SP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_phase  = 0;
    logic [KW-1:0]   cur_a = '0;
    logic [KW-1:0]   cur_b = '0;
    logic [2*KW-1:0] q_keys [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        m_phase = (m_phase + 1) % NP;
        chk("phase", 32'(bus.phase), m_phase);
    endtask

    function automatic logic [KW-1:0] exp_key();
        return (m_phase < SP) ? cur_a : cur_b;
    endfunction

    task automatic start_load(input logic sdv);
        bus.load_start = 1'b1;
        bus.key_sdv    = sdv;
        bus.key_sdi    = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.key_sdv    = 1'b0;
        chk("load_key_out_zero", 32'(bus.key_out), 0);
        chk("load_armed_zero", 32'(bus.armed), 0);
    endtask

    task automatic shift_bits(input logic [2*KW-1:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_sdv = 1'b1;
            bus.key_sdi = bits[i];
            tick();
        end
        bus.key_sdv = 1'b0;
        bus.key_sdi = 1'b0;
    endtask

    task automatic load_full(input logic [KW-1:0] a, input logic [KW-1:0] b, input logic sdv);
        q_keys.push_back({b, a});
        start_load(sdv);
        shift_bits({b, a}, 2 * KW);
        chk("load_done", 32'(bus.load_done), 1);
        if (bus.load_done && (q_keys.size() > 0)) begin
            {cur_b, cur_a} = q_keys.pop_front();
        end
        tick();
        chk("load_done_single", 32'(bus.load_done), 0);
    endtask

    task automatic wait_armed(input string tag);
        for (int i = 0; (i < 2 * NP) && !bus.armed; i++) begin
            chk({tag, "_pre_key_out"}, 32'(bus.key_out), 0);
            tick();
        end
        chk({tag, "_rise"}, 32'(bus.armed), 1);
        chk({tag, "_phase0"}, 32'(bus.phase), 0);
    endtask

    task automatic run_armed(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_armed"}, 32'(bus.armed), 1);
            chk({tag, "_key_out"}, 32'(bus.key_out), 32'(exp_key()));
            chk({tag, "_no_done"}, 32'(bus.load_done), 0);
            tick();
        end
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; (i < NP) && (m_phase != p); i++) begin
            tick();
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.key_sdv    = 1'b0;
        bus.key_sdi    = 1'b0;
        bus.arm        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        m_phase = 0;

        // Reset values and free-running phase.
        chk("rst_key_out", 32'(bus.key_out), 0);
        chk("rst_armed", 32'(bus.armed), 0);
        chk("rst_load_done", 32'(bus.load_done), 0);
        chk("rst_load_err", 32'(bus.load_err), 0);
        chk("rst_phase", 32'(bus.phase), 0);
        repeat (4) tick();

        // Sdv without load_start in IDLE is ignored: no load completes.
        shift_bits(14'h3FFF, 2 * KW);
        chk("idle_sdv_no_done", 32'(bus.load_done), 0);

        // Basic load and phase-aligned key drive.
        load_full(7'h7D, 7'h24, 1'b0);
        chk("ready_key_out", 32'(bus.key_out), 0);
        chk("ready_armed", 32'(bus.armed), 0);
        bus.arm = 1'b1;
        wait_armed("arm1");
        run_armed("run1", 8);
        bus.arm = 1'b0;
        tick();
        chk("disarm_key_out", 32'(bus.key_out), 0);
        chk("disarm_armed", 32'(bus.armed), 0);

        // Arm asserted mid-period takes effect only at phase 0.
        wait_phase(2);
        bus.arm = 1'b1;
        tick();
        chk("mid_arm_armed", 32'(bus.armed), 0);
        chk("mid_arm_key_out", 32'(bus.key_out), 0);
        tick();
        chk("mid_arm_rise", 32'(bus.armed), 1);
        chk("mid_arm_key_a", 32'(bus.key_out), 32'(exp_key()));
        bus.arm = 1'b0;
        tick();

        // Aborted load, then full reload; the restart bit carries sdv too.
        start_load(1'b0);
        shift_bits({7'h24, 7'h7D}, 9);
        chk("abort_no_done", 32'(bus.load_done), 0);
        chk("abort_err_clear", 32'(bus.load_err), 0);
        load_full(7'h11, 7'h22, 1'b1);
        chk("abort_err_set", 32'(bus.load_err), 1);
        bus.arm = 1'b1;
        wait_armed("arm2");
        run_armed("run2", 8);

        // Reload while armed, arm held throughout.
        load_full(7'h5A, 7'h33, 1'b0);
        wait_armed("arm3");
        run_armed("run3", 8);
        chk("err_sticky", 32'(bus.load_err), 1);

        // Reset while armed at phase 3.
        wait_phase(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_armed_key_out", 32'(bus.key_out), 0);
        chk("rst_armed_armed", 32'(bus.armed), 0);
        chk("rst_armed_err", 32'(bus.load_err), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_idle_armed", 32'(bus.armed), 0);
            chk("post_rst_idle_key_out", 32'(bus.key_out), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_phase_feeder.md
KEY_PHASE_FEEDER -- requirements
Module: key_phase_feeder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge), rst input 1 (synchronous, active-high).
REQ-002 Parameter KEY_W, default 7, SHALL set the width of one key word.
REQ-003 Parameter N_PHASE, default 4, SHALL set the phase period in cycles.
REQ-004 Parameter SPLIT, default 2, SHALL set the phases 0..SPLIT-1 that select key A; the remaining phases select key B.
REQ-005 load_start  input  1 SHALL be a pulse that begins a serial key load.
REQ-006 key_sdi  input  1 SHALL carry serial key data.
REQ-007 key_sdv  input  1 SHALL qualify key_sdi.
REQ-008 arm  input  1 SHALL be a level that enables key drive once a load is complete.
REQ-009 key_out  output  KEY_W SHALL be the key word driven to the downstream locked FSM; bit i maps to downstream keyinput i.
REQ-010 phase  output  $clog2(N_PHASE) SHALL be the current phase count.
REQ-011 load_done  output  1 SHALL pulse for 1 cycle when a load completes.
REQ-012 armed  output  1 SHALL be high while key_out carries a real key.
REQ-013 load_err  output  1 SHALL be a sticky flag for an aborted load.

Function
REQ-014 phase SHALL free-run 0,1,..,N_PHASE-1,0 every cycle regardless of FSM state, so it stays aligned with the downstream counter that also resets to 0.
REQ-015 The FSM SHALL have the states IDLE, LOADING, READY and ARMED.
REQ-016 IDLE: load_start SHALL go to LOADING and clear the bit counter; key_sdv SHALL be ignored.
REQ-017 LOADING: each cycle with key_sdv=1 SHALL shift one bit; bits 0..KEY_W-1 SHALL fill key_a[0..KEY_W-1], then bits KEY_W..2*KEY_W-1 SHALL fill key_b[0..KEY_W-1] (LSB first).
REQ-018 The bit counter SHALL be $clog2(2*KEY_W) bits wide and SHALL count 0..2*KEY_W-1 with no wrap.
REQ-019 On the cycle the final bit (index 2*KEY_W-1) is accepted, the FSM SHALL go to READY and load_done SHALL be 1 in the next cycle only.
REQ-020 load_start in LOADING SHALL restart the load (counter=0, staged bits discarded) and set load_err.
REQ-021 key_a and key_b SHALL be written into the staging registers only; the committed registers SHALL update only on the transition to READY.
REQ-022 READY: arm=1 SHALL go to ARMED at the next phase==0 boundary only, never mid-period.
REQ-023 READY: load_start SHALL go to LOADING.
REQ-024 ARMED: key_out SHALL equal committed key_a when the registered next phase < SPLIT, else committed key_b; it SHALL be registered and valid in the same cycle phase shows that value.
REQ-025 ARMED: arm=0 SHALL go to READY and key_out SHALL be 0 from the next cycle.
REQ-026 ARMED: load_start SHALL go to LOADING, key_out SHALL be 0 from the next cycle, and the old committed keys SHALL be retained until the new load completes.
REQ-027 In all states except ARMED, key_out SHALL be all-zero and armed SHALL be 0.
REQ-028 load_start and key_sdv in the same cycle SHALL treat load_start as dominant; that bit SHALL not be shifted.
REQ-029 load_err SHALL clear only on rst.

Reset
REQ-030 rst SHALL set: state IDLE; phase 0; bit counter 0; staging and committed keys 0; key_out 0; armed 0; load_done 0; load_err 0.
REQ-031 rst asserted mid-LOADING or mid-ARMED SHALL abort immediately with no partial commit.

Structure
REQ-032 The FSM state enum and the default KEY_W/N_PHASE/SPLIT constants SHALL reside in a shared package key_feed_pkg.
REQ-033 The serial shift/commit datapath SHALL be one sub-module, key_shift_reg; the FSM, phase counter and output mux SHALL stay in the top level.

Verification
REQ-034 Reset: after rst, all outputs SHALL be 0 and phase SHALL count 0,1,2,3,0 over 5 cycles.
REQ-035 Load key_a=7'h7D, key_b=7'h24 (14 bits), then arm=1: load_done SHALL pulse once, and from the next phase 0 key_out SHALL read 7D,7D,24,24 repeating.
REQ-036 Issue load_start after 9 bits, then a full reload with 7'h11/7'h22: load_err SHALL be 1, committed keys SHALL be 11/22, and no 7D value SHALL appear.
REQ-037 Assert arm at phase 2: armed SHALL rise only at the next phase 0, and key_out SHALL be 0 before that.
REQ-038 While ARMED, assert load_start: key_out SHALL be 0 the next cycle, and after 14 bits with arm held key_out SHALL resume with the new keys aligned to phase 0.
REQ-039 Assert rst during ARMED at phase 3: the next cycle SHALL show phase 0, key_out 0 and state IDLE.
